// File: rtl/fifo_serial_pkg.sv
// Shared definitions for the fifo serial transmit back end.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/fifo_serial_baud.sv
// Bit-period down-counter: reloads on restart, ticks for one cycle at zero.
module fifo_serial_baud #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  // Tick only while a frame is running so an idle zero count is harmless.
  assign bit_tick = active && (cnt_q == '0);

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the fifo head and sends start/data/parity/stop frames.
// tx is registered from the current state, so the line lags the FSM by one
// clock: the pop (strobe) cycle still shows idle-high on tx.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0]     fifo_q,
  input  logic                 fifo_used,
  output logic                 fifo_q_strobe,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic ODD_INV = (PARITY == PAR_ODD);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 strobe_q, strobe_d;

  logic                 pop;
  logic                 bit_tick;
  logic [DIV_WIDTH-1:0] baud_load;

  // A new frame may only start from IDLE with enable and data present.
  assign pop       = (state_q == ST_IDLE) && en && fifo_used;
  // The first period uses the live divisor since div_lat is loaded in parallel.
  assign baud_load = pop ? divisor : div_lat_q;

  fifo_serial_baud #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .active   (state_q != ST_IDLE),
    .restart  (pop || bit_tick),
    .load_val (baud_load),
    .bit_tick (bit_tick)
  );

  // FSM next state, datapath updates and registered-output next values.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    div_lat_d = div_lat_q;
    idx_d     = idx_q;
    par_d     = par_q;
    strobe_d  = 1'b0;
    tx_d      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shreg_d   = fifo_q;
          div_lat_d = divisor;
          idx_d     = '0;
          par_d     = 1'b0;
          strobe_d  = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_tick) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shreg_q[0];
        if (bit_tick) begin
          shreg_d = shreg_q >> 1;
          par_d   = par_q ^ shreg_q[0];
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q ^ ODD_INV;
        if (bit_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      div_lat_q <= '0;
      idx_q     <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      div_lat_q <= div_lat_d;
      idx_q     <= idx_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
    end
  end

  assign tx            = tx_q;
  assign busy          = busy_q;
  assign fifo_q_strobe = strobe_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench: three transmitters (no/even/odd parity) fed by queue
// models of the fifo head; every frame is checked cycle by cycle.
module tb_fifo_serial_tx;
  import fifo_serial_pkg::*;

  localparam int WIDTH = 8;
  localparam int DW    = 16;
  localparam int NI    = 3;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               div;
    int               cut;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              en;
  logic [DW-1:0]     divisor;
  logic [WIDTH-1:0]  fifo_q_w [NI];
  logic [NI-1:0]     fifo_used_w = '0;
  logic [NI-1:0]     strobe_w;
  logic [NI-1:0]     tx_w;
  logic [NI-1:0]     busy_w;

  logic [WIDTH-1:0]  fq [NI][$];
  frame_t            sb [NI][$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int strobe_cnt [NI] = '{default: 0};
  int last_t     [NI] = '{default: 0};
  int prev_t     [NI] = '{default: 0};
  int mon_busy   [NI] = '{default: 0};

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      fifo_serial_tx #(
        .WIDTH     (WIDTH),
        .DIV_WIDTH (DW),
        .PARITY    (gi)
      ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .divisor       (divisor),
        .fifo_q        (fifo_q_w[gi]),
        .fifo_used     (fifo_used_w[gi]),
        .fifo_q_strobe (strobe_w[gi]),
        .tx            (tx_w[gi]),
        .busy          (busy_w[gi])
      );
    end
  endgenerate

  always @(posedge clk) cyc <= cyc + 1;

  // Fifo head model: pops on the strobe cycle, presents the next word.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (strobe_w[i] === 1'b1 && fq[i].size() != 0) void'(fq[i].pop_front());
      fifo_used_w[i] = (fq[i].size() != 0);
      fifo_q_w[i]    = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int inst, input logic [WIDTH-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= WIDTH) return w[b-1];
    if (b == WIDTH + 1 && inst != 0) return (^w) ^ (inst == 2);
    return 1'b1;
  endfunction

  // Frame monitor for one instance: pairs each strobe with a scoreboard entry.
  task automatic mon(input int i);
    frame_t f;
    int nb, total, lim;
    forever begin
      @(negedge clk);
      if (strobe_w[i] === 1'b1) begin
        strobe_cnt[i]++;
        prev_t[i] = last_t[i];
        last_t[i] = cyc;
        check_eq($sformatf("i%0d_popcycle_tx", i), tx_w[i], 1);
        check_eq($sformatf("i%0d_popcycle_busy", i), busy_w[i], 1);
        check_eq($sformatf("i%0d_strobe_expected", i), sb[i].size() != 0, 1);
        if (sb[i].size() != 0) begin
          f = sb[i].pop_front();
          mon_busy[i] = 1;
          nb    = WIDTH + 2 + ((i != 0) ? 1 : 0);
          total = nb * (f.div + 1);
          lim   = (f.cut >= 0) ? f.cut : total;
          for (int t = 0; t < lim; t++) begin
            @(negedge clk);
            check_eq($sformatf("i%0d_w%02h_tx_t%0d", i, f.word, t), tx_w[i],
                     exp_bit(i, f.word, t / (f.div + 1)));
            check_eq($sformatf("i%0d_w%02h_busy_t%0d", i, f.word, t), busy_w[i], t < total - 1);
            check_eq($sformatf("i%0d_w%02h_strobe_t%0d", i, f.word, t), strobe_w[i], 0);
          end
          $display("frame inst=%0d word=%02h div=%0d cycles=%0d%s", i, f.word, f.div, lim,
                   (f.cut >= 0) ? " (aborted by reset)" : "");
          mon_busy[i] = 0;
        end
      end
    end
  endtask

  task automatic push_fifo(input int i, input logic [WIDTH-1:0] w);
    @(posedge clk);
    #1;
    fq[i].push_back(w);
  endtask

  task automatic push_sb(input int i, input logic [WIDTH-1:0] w, input int d, input int c);
    sb[i].push_back('{word: w, div: d, cut: c});
  endtask

  task automatic wait_idle(input int i, input int budget);
    int done = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sb[i].size() == 0 && mon_busy[i] == 0 && busy_w[i] === 1'b0) begin
        done = 1;
        break;
      end
    end
    check_eq($sformatf("i%0d_idle_reached", i), done, 1);
  endtask

  task automatic wait_strobe(input int i, input int budget);
    int seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (strobe_w[i] === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check_eq($sformatf("i%0d_strobe_seen", i), seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    reset   = 1'b0;
    en      = 1'b0;
    divisor = 16'd3;
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none

    // Reset held two clocks with data available and enable high.
    fq[0].push_back(8'hA5);
    push_sb(0, 8'hA5, 3, -1);
    en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check_eq($sformatf("rst%0d_i%0d_tx", r, i), tx_w[i], 1);
        check_eq($sformatf("rst%0d_i%0d_busy", r, i), busy_w[i], 0);
        check_eq($sformatf("rst%0d_i%0d_strobe", r, i), strobe_w[i], 0);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("pop_after_release", strobe_w[0], 1);
    wait_idle(0, 200);

    // Even and odd parity on 8'h07.
    push_fifo(1, 8'h07);
    push_sb(1, 8'h07, 3, -1);
    push_fifo(2, 8'h07);
    push_sb(2, 8'h07, 3, -1);
    wait_idle(1, 200);
    wait_idle(2, 200);

    // Back-to-back frames at one clock per bit.
    divisor = 16'd0;
    push_sb(0, 8'h55, 0, -1);
    push_sb(0, 8'hAA, 0, -1);
    push_fifo(0, 8'h55);
    push_fifo(0, 8'hAA);
    wait_idle(0, 200);
    check_eq("b2b_strobe_spacing", last_t[0] - prev_t[0], 11);

    // Enable drop and divisor change mid-frame.
    en      = 1'b0;
    divisor = 16'd3;
    push_fifo(0, 8'h3C);
    push_fifo(0, 8'hC3);
    push_sb(0, 8'h3C, 3, -1);
    en = 1'b1;
    wait_strobe(0, 50);
    @(negedge clk);
    en      = 1'b0;
    divisor = 16'd1;
    wait_idle(0, 300);
    snap = strobe_cnt[0];
    repeat (10) @(negedge clk);
    check_eq("no_pop_while_disabled", strobe_cnt[0], snap);
    check_eq("word_still_queued", fq[0].size(), 1);
    push_sb(0, 8'hC3, 1, -1);
    en = 1'b1;
    wait_idle(0, 300);

    // Reset during data bit 3 of a divisor-3 frame.
    divisor = 16'd3;
    push_fifo(0, 8'h5A);
    push_sb(0, 8'h5A, 3, 17);
    wait_strobe(0, 50);
    repeat (17) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_tx", tx_w[0], 1);
    check_eq("abort_busy", busy_w[0], 0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq($sformatf("post_abort_strobe_%0d", k), strobe_w[0], 0);
      check_eq($sformatf("post_abort_tx_%0d", k), tx_w[0], 1);
    end

    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("i%0d_sb_drained", i), sb[i].size(), 0);
    end
    check_eq("i0_strobe_total", strobe_cnt[0], 6);
    check_eq("i1_strobe_total", strobe_cnt[1], 1);
    check_eq("i2_strobe_total", strobe_cnt[2], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
